// File: rtl/motor_drive_ctrl.sv
// motor_drive_ctrl: converts the 2-bit tracker command into two wheel drives.
// The block holds one IDLE/RUN/BRAKE state machine and one ramped-duty PWM
// channel per wheel. Duty changes happen only on the free-running ramp tick,
// so a command flip never steps a motor from one speed straight to another.
module motor_drive_ctrl #(
  parameter int PWM_BITS  = 10,
  parameter int DUTY_FAST = 700,
  parameter int DUTY_SLOW = 300,
  parameter int RAMP_DIV  = 1000,
  parameter int RAMP_STEP = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_move,
  input  logic [1:0]          state,
  output logic                left_pwm,
  output logic                right_pwm,
  output logic [1:0]          left_dir,
  output logic [1:0]          right_dir,
  output logic [PWM_BITS-1:0] left_duty,
  output logic [PWM_BITS-1:0] right_duty,
  output logic [1:0]          motor_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    BRAKE = 2'b10
  } fsm_t;

  localparam int TICK_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(RAMP_DIV - 1);
  localparam logic [PWM_BITS-1:0] FAST      = PWM_BITS'(DUTY_FAST);
  localparam logic [PWM_BITS-1:0] SLOW      = PWM_BITS'(DUTY_SLOW);
  // Step in the widened (one extra bit) domain used for the ramp compares,
  // and the same step at duty width for the actual subtraction.
  localparam logic [PWM_BITS:0]   STEP_X    = (PWM_BITS + 1)'(RAMP_STEP);
  localparam logic [PWM_BITS-1:0] STEP_N    = PWM_BITS'(RAMP_STEP);
  localparam logic [1:0]          DIR_FWD   = 2'b10;
  localparam logic [1:0]          DIR_COAST = 2'b00;

  fsm_t                fsm_reg;
  logic [1:0]          left_dir_reg;
  logic [1:0]          right_dir_reg;
  logic [TICK_W-1:0]   tick_cnt_reg;
  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic                tick;
  logic                go_cmd;
  logic                duties_zero;
  logic [PWM_BITS-1:0] target [2];

  // A motion request is an enabled, non-stop command.
  assign go_cmd = start_move && (state != 2'b00);
  assign tick   = (tick_cnt_reg == TICK_LAST);

  // Ramp prescaler: free-running from reset, never restarted by the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_reg <= '0;
    end else if (tick) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + TICK_W'(1);
    end
  end

  // PWM carrier: wraps naturally at 2^PWM_BITS.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_reg <= '0;
    end else begin
      pwm_cnt_reg <= pwm_cnt_reg + PWM_BITS'(1);
    end
  end

  // Per-wheel ramp targets; only RUN ever asks for non-zero speed.
  always_comb begin
    target[0] = '0;
    target[1] = '0;
    if (fsm_reg == RUN) begin
      case (state)
        2'b11: begin target[0] = FAST; target[1] = FAST; end
        2'b10: begin target[0] = SLOW; target[1] = FAST; end
        2'b01: begin target[0] = FAST; target[1] = SLOW; end
        default: begin target[0] = '0; target[1] = '0; end
      endcase
    end
  end

  // Index 0 is the left wheel, index 1 the right wheel.
  for (genvar gi = 0; gi < 2; gi++) begin : wheel
    logic [PWM_BITS-1:0] duty_reg;
    logic [PWM_BITS-1:0] duty_next;
    logic                pwm_reg;
    logic [PWM_BITS:0]   duty_x;
    logic [PWM_BITS:0]   tgt_x;
    logic [PWM_BITS:0]   up_x;
    logic [PWM_BITS:0]   gap_x;

    // Saturating step toward the target; the extra bit keeps duty+STEP and
    // duty-target free of wrap, and the target acts as the clamp both ways.
    always_comb begin
      duty_x    = {1'b0, duty_reg};
      tgt_x     = {1'b0, target[gi]};
      up_x      = duty_x + STEP_X;
      gap_x     = duty_x - tgt_x;
      duty_next = duty_reg;
      if (duty_x < tgt_x) begin
        duty_next = (up_x >= tgt_x) ? target[gi] : up_x[PWM_BITS-1:0];
      end else if (duty_x > tgt_x) begin
        duty_next = (gap_x > STEP_X) ? (duty_reg - STEP_N) : target[gi];
      end
    end

    // Duty only moves on a tick; PWM compare is registered and gated off in IDLE.
    always_ff @(posedge clk) begin
      if (reset) begin
        duty_reg <= '0;
        pwm_reg  <= 1'b0;
      end else begin
        if (tick) begin
          duty_reg <= duty_next;
        end
        pwm_reg <= (fsm_reg != IDLE) && (pwm_cnt_reg < duty_reg);
      end
    end
  end

  assign duties_zero = (wheel[0].duty_reg == '0) && (wheel[1].duty_reg == '0);

  // Motion FSM; direction pins are registered alongside the state so both
  // change on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_reg       <= IDLE;
      left_dir_reg  <= DIR_COAST;
      right_dir_reg <= DIR_COAST;
    end else begin
      case (fsm_reg)
        IDLE: begin
          if (go_cmd) begin
            fsm_reg       <= RUN;
            left_dir_reg  <= DIR_FWD;
            right_dir_reg <= DIR_FWD;
          end
        end
        RUN: begin
          // Command changes in RUN only retarget the ramp.
          if (!go_cmd) begin
            fsm_reg <= BRAKE;
          end
        end
        BRAKE: begin
          // Resume wins over finishing the stop; ramp continues from current duty.
          if (go_cmd) begin
            fsm_reg <= RUN;
          end else if (duties_zero) begin
            fsm_reg       <= IDLE;
            left_dir_reg  <= DIR_COAST;
            right_dir_reg <= DIR_COAST;
          end
        end
        default: begin
          fsm_reg       <= IDLE;
          left_dir_reg  <= DIR_COAST;
          right_dir_reg <= DIR_COAST;
        end
      endcase
    end
  end

  assign motor_state = fsm_reg;
  assign left_dir    = left_dir_reg;
  assign right_dir   = right_dir_reg;
  assign left_duty   = wheel[0].duty_reg;
  assign right_duty  = wheel[1].duty_reg;
  assign left_pwm    = wheel[0].pwm_reg;
  assign right_pwm   = wheel[1].pwm_reg;

endmodule

// File: doc/motor_drive_ctrl.md
# motor_drive_ctrl

Consumes the 2-bit motion command produced by the line-tracker policy and drives the two wheel motors: per-wheel direction pins plus PWM enables. Sits between the tracker block and the H-bridge pins on the car top level. Adds soft speed ramping and a controlled braking sequence so command flips never step the motors hard.

## Interface
- PWM_BITS, 10, width of PWM counter and duty registers; PWM period is 2^PWM_BITS cycles
- DUTY_FAST, 700, duty of the outer or straight wheel
- DUTY_SLOW, 300, duty of the inner wheel while turning
- RAMP_DIV, 1000, clk cycles per ramp tick (≥2)
- RAMP_STEP, 20, duty change per ramp tick (≥1)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset; one clock domain
- start_move  in  1  motion enable; low forces braking to stop
- state  in  2  command: 00 stop, 01 turn right, 10 turn left, 11 go straight
- left_pwm  out  1  left motor enable (PWM)
- right_pwm  out  1  right motor enable (PWM)
- left_dir  out  2  left H-bridge IN1/IN2: 10 forward, 00 coast
- right_dir  out  2  right H-bridge IN1/IN2: 10 forward, 00 coast
- left_duty  out  PWM_BITS  current left duty (registered)
- right_duty  out  PWM_BITS  current right duty (registered)
- motor_state  out  2  FSM state: 00 IDLE, 01 RUN, 10 BRAKE

## Operation
- Targets (L,R): 11 → (FAST,FAST); 10 → (SLOW,FAST); 01 → (FAST,SLOW); 00 → (0,0). In IDLE and BRAKE both targets are 0.
- FSM:
  - IDLE: duties 0, dirs 00, pwm 0. Go to RUN when start_move=1 and state≠00.
  - RUN: dirs 10. Duties ramp toward targets. Go to BRAKE when start_move=0 or state=00.
  - BRAKE: dirs 10, targets 0.
    - Go to RUN when start_move=1 and state≠00. Ramping resumes from the current duties with no reset.
    - Otherwise go to IDLE once both duties are 0.
    - The resume condition takes priority when both conditions hold.
- Ramp tick:
  - tick_cnt counts 0..RAMP_DIV-1 and wraps; it is free-running from reset and not restarted by the FSM.
  - tick is asserted when tick_cnt = RAMP_DIV-1.
  - On each tick, each duty moves toward its own target. Increase: duty = min(duty+STEP, target). Decrease: duty = max(duty-STEP, target).
  - Arithmetic is done in PWM_BITS+1 bits, with no wrap or underflow.
  - Duties never change on a non-tick cycle.
- PWM:
  - pwm_cnt is free-running 0..2^PWM_BITS-1 and wraps to 0.
  - pwm_out is registered as (pwm_cnt < duty). Duty 0 gives a constant 0.
  - pwm is forced to 0 in IDLE.
- Command changes in RUN only retarget the ramp. The FSM does not change state.

## Timing
- Reset (synchronous, sampled on clk rising edge) clears everything. All outputs are 0 and motor_state is IDLE on the first cycle after reset is sampled.
- FSM transitions take effect one clk after the sampled condition. dir outputs change in the same cycle as motor_state.
- Duty changes are visible on left_duty/right_duty in the cycle after a tick.
- pwm lags the compare of pwm_cnt against duty by 1 cycle.
- With ramp period T = RAMP_DIV, 0→DUTY_FAST takes ceil(FAST/STEP) ticks.
- BRAKE→IDLE happens one cycle after both duties read 0.
- Reset asserted mid-RUN or mid-BRAKE aborts immediately. No ramp-down occurs.

## Test plan
Bench parameters: PWM_BITS=4, FAST=12, SLOW=6, RAMP_DIV=4, STEP=4.
1. Reset, then start_move=0 and state=11 for 40 cycles → outputs all 0, motor_state=00 throughout.
2. start_move=1, state=11 → motor_state=01 and dirs 10/10 next cycle. Duties step 4, 8, 12 on successive ticks, then hold. Each pwm is high 12 of every 16 cycles.
3. From (12,12), state=10 → left steps 8 then 6 (clamped), right stays 12. left_pwm is high 6/16.
4. state=00 → BRAKE. Both duties fall by 4 per tick (6→2→0, 12→8→4→0). IDLE follows one cycle after both are 0, with dirs 00 and pwm 0.
5. In BRAKE with left=8, right=8, set state=11 → motor_state=01 next cycle, duties rise 12 from 8 with no drop to 0.
6. Assert reset for one cycle mid-RUN with duties (12,12) → next cycle all outputs 0 and IDLE. With start_move still 1, RUN is re-entered on the following cycle and ramps from 0.
